key_event_ctrl: RTL
===================

# key_event_ctrl

Event controller behind a bank of `key_filter` instances. It turns each key's debounced `key_flag`/`key_state` pair into press, release, long-press and auto-repeat events. Simultaneous events from several keys are shared round-robin into one small event FIFO, and the FIFO drains to a single consumer over a valid/ready handshake. It sits between the per-key filters and application logic such as a menu or counter controller.

## Interface
- `N_KEYS`, default 4: number of filtered keys, 2..8.
- `LONG_CNT`, default 50_000_000: cycles of continuous press before the LONG event (1 s at 50 MHz).
- `REPEAT_CNT`, default 10_000_000: cycles between REPEAT events after LONG (200 ms).
- `FIFO_DEPTH`, default 4: event FIFO entries, power of two.
- `Clk`  in  1  system clock; sole clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `key_flag`  in  N_KEYS  per-key one-cycle pulse from `key_filter` when the debounced level changes.
- `key_state`  in  N_KEYS  per-key debounced level: 1 = released, 0 = pressed. Valid on the `key_flag` cycle.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head this cycle.
- `evt_key`  out  clog2(N_KEYS)  key index of the head event.
- `evt_type`  out  2  event code: 0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT.
- `overflow`  out  1  sticky; set when an event is dropped. Cleared only by `Reset`.

## Operation
- Each key has its own FSM with states IDLE, PRESSED, HELD, and a 32-bit hold counter.
- IDLE:
  - `key_flag` with `key_state`=0 raises PRESS and moves to PRESSED with counter=0.
  - `key_flag` with `key_state`=1 is ignored.
- PRESSED:
  - The counter increments every cycle.
  - counter==LONG_CNT-1 raises LONG, moves to HELD, and clears the counter.
- HELD:
  - The counter increments every cycle.
  - counter==REPEAT_CNT-1 raises REPEAT and clears the counter, so REPEAT fires every REPEAT_CNT cycles.
- PRESSED/HELD: `key_flag` with `key_state`=1 raises RELEASE, moves to IDLE and clears the counter.
- Same-cycle conflict: if RELEASE and a LONG/REPEAT terminal count land on the same cycle, RELEASE wins and no LONG/REPEAT is raised.
- Pending slots:
  - Each key has one pending slot holding a valid bit and a type. A raised event is written there.
  - If the slot is still occupied, the new event is dropped and `overflow` is set. The FSM transitions regardless.
- Arbiter:
  - Each cycle, if the FIFO is not full, grant exactly one key with an occupied slot.
  - Priority is round-robin. After granting key k, search starts at k+1 mod N_KEYS.
  - The granted slot is pushed into the FIFO and cleared on the same edge.
- FIFO:
  - Show-ahead: `evt_valid` = not empty, and `evt_key`/`evt_type` present the head.
  - Pop on `evt_valid && evt_ready`.
  - Push is allowed only when not full, evaluated before that cycle's pop; a full FIFO does not push even while popping.
  - Pop when empty is a no-op.
- Reset:
  - `evt_valid`=0, `evt_key`=0, `evt_type`=0, `overflow`=0.
  - All FSMs go to IDLE, counters and slots clear, the FIFO empties, and the round-robin pointer returns to 0.
  - Asserting `Reset` mid-operation discards every queued and pending event on that edge.
- A key already pressed when reset deasserts generates nothing until its next `key_flag`.

## Timing
- `key_flag` sampled at edge t, slot written at t: pending.
- Grant and FIFO push at edge t+1. `evt_valid`=1 after edge t+1, i.e. 2 cycles from the flag edge when the FIFO is empty and no other slot competes.
- LONG is raised LONG_CNT cycles after the PRESS-raising edge.
- The first REPEAT follows LONG by REPEAT_CNT cycles.
- With all N_KEYS slots occupied and the FIFO draining every cycle, the last key waits at most N_KEYS-1 extra cycles.
- The FIFO accepts one push and one pop per cycle when neither full nor empty.
- Count widths:
  - Counter compares are exact equality; a parameter of 1 fires every cycle.
  - Parameters of 0 are illegal.
  - LONG_CNT and REPEAT_CNT must fit in 32 bits.

## Test plan
Overrides: LONG_CNT=10, REPEAT_CNT=4, N_KEYS=4, FIFO_DEPTH=4, `evt_ready`=1 unless stated.

1. Short tap:
   - Stimulus: key1 press flag, release flag 5 cycles later.
   - Required: (1,PRESS) with `evt_valid` 2 cycles after the first flag, then (1,RELEASE); no LONG.
2. Long hold:
   - Stimulus: key2 pressed for 25 cycles.
   - Required: PRESS; LONG 10 cycles after PRESS; REPEAT at +4 and +8 and +12 after LONG; then RELEASE.
3. Simultaneous press:
   - Stimulus: flags on keys 0, 2 and 3 in one cycle.
   - Required: FIFO order 0, 2, 3, one grant per cycle. A repeat of the stimulus starts the search at key 0 again, since the pointer is past 3.
4. Backpressure:
   - Stimulus: `evt_ready`=0; six press/release flags on key0.
   - Required: exactly 4 events queued plus 1 pending; later events dropped; `overflow`=1 and sticky.
   - Then `evt_ready`=1: 5 events drain in order.
5. Release on terminal cycle:
   - Stimulus: key3 release flag on the exact cycle LONG would fire.
   - Required: PRESS, RELEASE only; no LONG.
6. Reset mid-hold:
   - Stimulus: `Reset` pulse while key1 is in HELD with 2 events queued.
   - Required: `evt_valid`=0 the next cycle and `overflow`=0. No further events from key1 until a new press flag.

Source files
------------

// File: rtl/key_event_ctrl.sv
// key_event_ctrl
//   Turns per-key debounced flag/level pairs from a bank of key filters into
//   PRESS / RELEASE / LONG / REPEAT events. Each key owns a small FSM, a hold
//   counter and a one-entry pending slot; a round-robin arbiter moves one
//   pending event per cycle into a show-ahead FIFO read over valid/ready.
//
// Ports
//   Clk        system clock (single domain)
//   Reset      synchronous, active-high reset
//   key_flag   per-key one-cycle pulse on debounced level change
//   key_state  per-key debounced level (1 = released, 0 = pressed)
//   evt_valid  FIFO head holds an event
//   evt_ready  consumer accepts the head this cycle
//   evt_key    key index of the head event
//   evt_type   0 PRESS, 1 RELEASE, 2 LONG, 3 REPEAT
//   overflow   sticky; an event was dropped because its key's slot was busy
module key_event_ctrl #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned LONG_CNT   = 50_000_000,
  parameter int unsigned REPEAT_CNT = 10_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [N_KEYS-1:0]           key_flag,
  input  logic [N_KEYS-1:0]           key_state,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(N_KEYS)-1:0]   evt_key,
  output logic [1:0]                  evt_type,
  output logic                        overflow
);

  localparam int unsigned KW = $clog2(N_KEYS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [31:0] LONG_TC   = 32'(LONG_CNT - 1);
  localparam logic [31:0] REPEAT_TC = 32'(REPEAT_CNT - 1);

  localparam logic [1:0] EvPress   = 2'd0;
  localparam logic [1:0] EvRelease = 2'd1;
  localparam logic [1:0] EvLong    = 2'd2;
  localparam logic [1:0] EvRepeat  = 2'd3;

  typedef enum logic [1:0] {StIdle, StPressed, StHeld} state_e;

  // Per-key state
  state_e            r_st     [N_KEYS];
  logic [31:0]       r_cnt    [N_KEYS];
  logic [N_KEYS-1:0] r_pend_v;
  logic [1:0]        r_pend_t [N_KEYS];
  logic              r_overflow;

  // Event raised by each key on the coming edge
  logic [N_KEYS-1:0] w_raise;
  logic [1:0]        w_rtype  [N_KEYS];

  // Arbiter
  logic [KW-1:0]     r_ptr;
  logic [KW-1:0]     w_idx;
  logic              w_gnt;
  logic [KW-1:0]     w_gnt_idx;
  logic [N_KEYS-1:0] w_gnt_oh;

  // FIFO; pointers carry one wrap bit to tell full from empty
  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic [KW+1:0]     r_mem [FIFO_DEPTH];
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic [KW+1:0]     w_head;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = !w_empty && evt_ready;
  assign w_head  = r_mem[r_rd[AW-1:0]];

  assign evt_valid = !w_empty;
  assign evt_key   = w_head[KW+1:2];
  assign evt_type  = w_head[1:0];
  assign overflow  = r_overflow;

  // Event decode. A release flag takes precedence over a terminal count on
  // the same cycle, so LONG/REPEAT is suppressed then.
  always_comb begin
    for (int unsigned k = 0; k < N_KEYS; k++) begin
      w_raise[k] = 1'b0;
      w_rtype[k] = EvPress;
      unique case (r_st[k])
        StIdle: begin
          if (key_flag[k] && !key_state[k]) begin
            w_raise[k] = 1'b1;
            w_rtype[k] = EvPress;
          end
        end
        StPressed: begin
          if (key_flag[k] && key_state[k]) begin
            w_raise[k] = 1'b1;
            w_rtype[k] = EvRelease;
          end else if (r_cnt[k] == LONG_TC) begin
            w_raise[k] = 1'b1;
            w_rtype[k] = EvLong;
          end
        end
        StHeld: begin
          if (key_flag[k] && key_state[k]) begin
            w_raise[k] = 1'b1;
            w_rtype[k] = EvRelease;
          end else if (r_cnt[k] == REPEAT_TC) begin
            w_raise[k] = 1'b1;
            w_rtype[k] = EvRepeat;
          end
        end
        default: ;
      endcase
    end
  end

  // Round-robin search starting at r_ptr; no grant while the FIFO is full,
  // even if it pops on the same edge.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    for (int unsigned i = 0; i < N_KEYS; i++) begin
      w_idx = KW'((32'(r_ptr) + i) % N_KEYS);
      if (!w_gnt && r_pend_v[w_idx]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    if (w_full) begin
      w_gnt = 1'b0;
    end
    w_gnt_oh = '0;
    if (w_gnt) begin
      w_gnt_oh[w_gnt_idx] = 1'b1;
    end
  end

  // Key FSMs, counters and pending slots
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        r_st[k]     <= StIdle;
        r_cnt[k]    <= '0;
        r_pend_t[k] <= EvPress;
      end
      r_pend_v   <= '0;
      r_overflow <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_KEYS; k++) begin
        unique case (r_st[k])
          StIdle: begin
            if (key_flag[k] && !key_state[k]) begin
              r_st[k]  <= StPressed;
              r_cnt[k] <= '0;
            end
          end
          StPressed: begin
            if (key_flag[k] && key_state[k]) begin
              r_st[k]  <= StIdle;
              r_cnt[k] <= '0;
            end else if (r_cnt[k] == LONG_TC) begin
              r_st[k]  <= StHeld;
              r_cnt[k] <= '0;
            end else begin
              r_cnt[k] <= r_cnt[k] + 32'd1;
            end
          end
          StHeld: begin
            if (key_flag[k] && key_state[k]) begin
              r_st[k]  <= StIdle;
              r_cnt[k] <= '0;
            end else if (r_cnt[k] == REPEAT_TC) begin
              r_cnt[k] <= '0;
            end else begin
              r_cnt[k] <= r_cnt[k] + 32'd1;
            end
          end
          default: begin
            r_st[k]  <= StIdle;
            r_cnt[k] <= '0;
          end
        endcase

        // A slot being granted this edge counts as free for a new event.
        if (w_raise[k] && (!r_pend_v[k] || w_gnt_oh[k])) begin
          r_pend_v[k] <= 1'b1;
          r_pend_t[k] <= w_rtype[k];
        end else if (w_gnt_oh[k]) begin
          r_pend_v[k] <= 1'b0;
        end

        if (w_raise[k] && r_pend_v[k] && !w_gnt_oh[k]) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // Arbiter pointer and FIFO
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ptr <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_gnt) begin
        r_ptr                <= (w_gnt_idx == KW'(N_KEYS - 1)) ? '0 : w_gnt_idx + 1'b1;
        r_mem[r_wr[AW-1:0]]  <= {w_gnt_idx, r_pend_t[w_gnt_idx]};
        r_wr                 <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
    end
  end

endmodule
